// File: rtl/proj_pkg.sv
// Shared types and constants for the QKV projection sequencer and its users.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package proj_pkg;

    // Sequencer FSM encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] proj_state_t;
    localparam proj_state_t ST_IDLE  = 2'd0;
    localparam proj_state_t ST_START = 2'd1;
    localparam proj_state_t ST_RUN   = 2'd2;
    localparam proj_state_t ST_DRAIN = 2'd3;

    // Sticky error flag bit positions.
    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_SPURIOUS = 1;

    // Result width: product of two DW-bit values accumulated over n terms.
    function automatic int proj_aw(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Head index width, never narrower than one bit.
    function automatic int proj_iw(input int pe_num);
        return (pe_num > 1) ? $clog2(pe_num) : 1;
    endfunction

endpackage

// File: rtl/proj_sequencer_if.sv
// Bundle of the token, projection-unit and head-stream handshakes.
// Latency: n/a (wires only).
// Backpressure: tok_ready / hd_ready carry the valid/ready stalls.
// master = sequencer side, slave = environment side (upstream, proj unit, attention).
interface proj_sequencer_if #(
    parameter int N      = 768,
    parameter int DW     = 4,
    parameter int PE_NUM = 12
) ();
    import proj_pkg::*;

    localparam int AW = proj_aw(DW, N);
    localparam int IW = proj_iw(PE_NUM);

    // Upstream token
    logic                 tok_valid;
    logic                 tok_ready;
    logic signed [DW-1:0] tok_vec [N];
    // Projection unit
    logic                 proj_start;
    logic                 proj_in_valid;
    logic signed [DW-1:0] proj_in_vec [N];
    logic                 proj_out_valid;
    logic signed [AW-1:0] proj_out_q [PE_NUM];
    logic signed [AW-1:0] proj_out_k [PE_NUM];
    logic signed [AW-1:0] proj_out_v [PE_NUM];
    // Head stream to attention
    logic                 hd_valid;
    logic                 hd_ready;
    logic [IW-1:0]        hd_idx;
    logic signed [AW-1:0] hd_q;
    logic signed [AW-1:0] hd_k;
    logic signed [AW-1:0] hd_v;
    logic                 hd_last;

    modport master (
        input  tok_valid, tok_vec, proj_out_valid, proj_out_q, proj_out_k, proj_out_v, hd_ready,
        output tok_ready, proj_start, proj_in_valid, proj_in_vec,
        output hd_valid, hd_idx, hd_q, hd_k, hd_v, hd_last
    );

    modport slave (
        output tok_valid, tok_vec, proj_out_valid, proj_out_q, proj_out_k, proj_out_v, hd_ready,
        input  tok_ready, proj_start, proj_in_valid, proj_in_vec,
        input  hd_valid, hd_idx, hd_q, hd_k, hd_v, hd_last
    );

endinterface

// File: rtl/proj_sequencer_head_drain_buf.sv
// Captures PE_NUM q/k/v results and streams them one head per beat.
// Latency: first beat valid the cycle after cap_en; one head per accepted beat.
// Backpressure: holds idx and data stable while hd_valid && !hd_ready.
// Ports: clk/rst, cap_en + cap_q/k/v (capture), hd_* (valid/ready stream), done (last beat taken).
module head_drain_buf #(
    parameter int PE_NUM = 12,
    parameter int AW     = 18,
    parameter int IW     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_en,
    input  logic signed [AW-1:0] cap_q [PE_NUM],
    input  logic signed [AW-1:0] cap_k [PE_NUM],
    input  logic signed [AW-1:0] cap_v [PE_NUM],
    output logic                 hd_valid,
    input  logic                 hd_ready,
    output logic [IW-1:0]        hd_idx,
    output logic signed [AW-1:0] hd_q,
    output logic signed [AW-1:0] hd_k,
    output logic signed [AW-1:0] hd_v,
    output logic                 hd_last,
    output logic                 done
);
    localparam logic [IW-1:0] IDX_LAST = IW'(PE_NUM - 1);

    logic                 vld_q, vld_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic signed [AW-1:0] q_q [PE_NUM];
    logic signed [AW-1:0] q_d [PE_NUM];
    logic signed [AW-1:0] k_q [PE_NUM];
    logic signed [AW-1:0] k_d [PE_NUM];
    logic signed [AW-1:0] v_q [PE_NUM];
    logic signed [AW-1:0] v_d [PE_NUM];
    logic                 fire;
    logic                 at_last;

    assign fire    = vld_q && hd_ready;
    assign at_last = (idx_q == IDX_LAST);

    always_comb begin
        vld_d = vld_q;
        idx_d = idx_q;
        q_d   = q_q;
        k_d   = k_q;
        v_d   = v_q;
        if (cap_en) begin
            q_d   = cap_q;
            k_d   = cap_k;
            v_d   = cap_v;
            vld_d = 1'b1;
            idx_d = '0;
        end else if (fire) begin
            if (at_last) begin
                idx_d = '0;
                vld_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            idx_q <= '0;
            for (int i = 0; i < PE_NUM; i++) begin
                q_q[i] <= '0;
                k_q[i] <= '0;
                v_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
            q_q   <= q_d;
            k_q   <= k_d;
            v_q   <= v_d;
        end
    end

    assign hd_valid = vld_q;
    assign hd_idx   = idx_q;
    assign hd_q     = q_q[idx_q];
    assign hd_k     = k_q[idx_q];
    assign hd_v     = v_q[idx_q];
    assign hd_last  = vld_q && at_last;
    assign done     = fire && at_last;

endmodule

// File: rtl/proj_sequencer.sv
// Initiator-side sequencer: token in -> projection unit run -> per-head result stream.
// Latency: accept T, proj_start T+1, RUN from T+2; first head beat one cycle after proj_out_valid.
// Backpressure: single token in flight; tok_ready only in IDLE; head stream stalls on hd_ready.
// Ports: clk/rst, bus (proj_sequencer_if.master), busy, err[1:0] sticky, err_clr.
module proj_sequencer
    import proj_pkg::*;
#(
    parameter int N       = 768,
    parameter int DW      = 4,
    parameter int PE_NUM  = 12,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    proj_sequencer_if.master  bus,
    output logic              busy,
    output logic [1:0]        err,
    input  logic              err_clr
);
    localparam int AW = proj_aw(DW, N);
    localparam int IW = proj_iw(PE_NUM);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    proj_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           err_q, err_d;
    logic signed [DW-1:0] vec_q [N];
    logic signed [DW-1:0] vec_d [N];
    logic                 cap_en;
    logic                 drain_done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        cap_en  = 1'b0;
        // Clear first so that a flag raised this same cycle survives.
        err_d   = err_clr ? 2'b00 : err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.tok_valid) begin
                    vec_d   = bus.tok_vec;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                // A result arriving on the final timeout cycle still wins.
                if (bus.proj_out_valid) begin
                    cap_en  = 1'b1;
                    state_d = ST_DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A result pulse outside RUN has no request behind it.
        if (bus.proj_out_valid && (state_q != ST_RUN)) err_d[ERR_SPURIOUS] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            for (int i = 0; i < N; i++) vec_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
        end
    end

    assign bus.tok_ready     = (state_q == ST_IDLE);
    assign bus.proj_start    = (state_q == ST_START);
    assign bus.proj_in_valid = (state_q == ST_START) || (state_q == ST_RUN);
    assign bus.proj_in_vec   = vec_q;
    assign busy              = (state_q != ST_IDLE);
    assign err               = err_q;

    logic                 hd_valid_w;
    logic [IW-1:0]        hd_idx_w;
    logic signed [AW-1:0] hd_q_w, hd_k_w, hd_v_w;
    logic                 hd_last_w;

    head_drain_buf #(
        .PE_NUM (PE_NUM),
        .AW     (AW),
        .IW     (IW)
    ) u_drain (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (cap_en),
        .cap_q    (bus.proj_out_q),
        .cap_k    (bus.proj_out_k),
        .cap_v    (bus.proj_out_v),
        .hd_valid (hd_valid_w),
        .hd_ready (bus.hd_ready),
        .hd_idx   (hd_idx_w),
        .hd_q     (hd_q_w),
        .hd_k     (hd_k_w),
        .hd_v     (hd_v_w),
        .hd_last  (hd_last_w),
        .done     (drain_done)
    );

    assign bus.hd_valid = hd_valid_w;
    assign bus.hd_idx   = hd_idx_w;
    assign bus.hd_q     = hd_q_w;
    assign bus.hd_k     = hd_k_w;
    assign bus.hd_v     = hd_v_w;
    assign bus.hd_last  = hd_last_w;

endmodule

// File: tb/tb_proj_sequencer.sv
// Directed bench for proj_sequencer with a 5-cycle projection-unit responder.
// Latency: n/a.
// Backpressure: hd_ready driven directly by the stimulus sequence.
module tb_proj_sequencer;
    import proj_pkg::*;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int PE = 2;
    localparam int TO = 16;
    localparam int AW = proj_aw(DW, N);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic       busy;
    logic [1:0] err;
    logic       resp_pov = 1'b0;
    logic       man_pov = 1'b0;
    bit         resp_en = 1'b1;
    int         cd = 0;
    int         resp_b = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n = 0;
    bit         seen_hd = 1'b0;

    proj_sequencer_if #(.N(N), .DW(DW), .PE_NUM(PE)) bus ();

    assign bus.proj_out_valid = resp_pov | man_pov;

    proj_sequencer #(.N(N), .DW(DW), .PE_NUM(PE), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .err     (err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    // Projection-unit model: answers 5 cycles after proj_start; every result is
    // offset by token element 0 so back-to-back tokens give distinct results.
    always @(posedge clk) begin
        #1;
        resp_b = int'(bus.proj_in_vec[0]);
        if (rst) begin
            cd       = 0;
            resp_pov = 1'b0;
        end else begin
            resp_pov = 1'b0;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    resp_pov = 1'b1;
                    bus.proj_out_q[0] = AW'(3 + resp_b);
                    bus.proj_out_q[1] = AW'(-2 + resp_b);
                    bus.proj_out_k[0] = AW'(7 + resp_b);
                    bus.proj_out_k[1] = AW'(1 + resp_b);
                    bus.proj_out_v[0] = AW'(-8 + resp_b);
                    bus.proj_out_v[1] = AW'(4 + resp_b);
                end
            end
            if (bus.proj_start && resp_en) cd = 5;
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_tok(input int b);
        bus.tok_vec[0] = DW'(b);
        bus.tok_vec[1] = 4'sd5;
        bus.tok_vec[2] = -4'sd3;
        bus.tok_vec[3] = 4'sd7;
    endtask

    // Tick until hd_valid rises or the budget runs out; count = ticks taken.
    task automatic wait_hd(output int cnt);
        cnt = 0;
        while (!bus.hd_valid && cnt < 50) begin
            tick();
            cnt++;
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input int b, input bit last);
        chk({tag, ".vld"},  bus.hd_valid, 1);
        chk({tag, ".idx"},  bus.hd_idx, idx);
        chk({tag, ".q"},    bus.hd_q, (idx == 0) ? 3 + b : -2 + b);
        chk({tag, ".k"},    bus.hd_k, (idx == 0) ? 7 + b : 1 + b);
        chk({tag, ".v"},    bus.hd_v, (idx == 0) ? -8 + b : 4 + b);
        chk({tag, ".last"}, bus.hd_last, last);
    endtask

    // One complete token with hd_ready high, starting and ending in IDLE.
    task automatic full_token(input string tag, input int b);
        set_tok(b);
        bus.tok_valid = 1'b1;
        chk({tag, ".rdy0"}, bus.tok_ready, 1);
        tick();
        bus.tok_valid = 1'b0;
        chk({tag, ".start"}, bus.proj_start, 1);
        tick();
        wait_hd(n);
        chk({tag, ".lat"}, n, 5);
        chk_beat({tag, ".b0"}, 0, b, 1'b0);
        tick();
        chk_beat({tag, ".b1"}, 1, b, 1'b1);
        tick();
        chk({tag, ".rdy1"}, bus.tok_ready, 1);
        chk({tag, ".hdv"}, bus.hd_valid, 0);
    endtask

    initial begin
        bus.tok_valid = 1'b0;
        bus.hd_ready  = 1'b1;
        set_tok(0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state
        chk("rst.tok_ready", bus.tok_ready, 1);
        chk("rst.start", bus.proj_start, 0);
        chk("rst.in_valid", bus.proj_in_valid, 0);
        chk("rst.in_vec1", bus.proj_in_vec[1], 0);
        chk("rst.hd_valid", bus.hd_valid, 0);
        chk("rst.hd_idx", bus.hd_idx, 0);
        chk("rst.hd_q", bus.hd_q, 0);
        chk("rst.hd_last", bus.hd_last, 0);
        chk("rst.busy", busy, 0);
        chk("rst.err", err, 0);

        // Basic token, detailed timing
        set_tok(0);
        bus.tok_valid = 1'b1;
        tick();
        bus.tok_valid = 1'b0;
        chk("t1.start", bus.proj_start, 1);
        chk("t1.in_valid_s", bus.proj_in_valid, 1);
        chk("t1.tok_ready_s", bus.tok_ready, 0);
        chk("t1.in_vec2", bus.proj_in_vec[2], -3);
        chk("t1.busy", busy, 1);
        tick();
        chk("t1.start_off", bus.proj_start, 0);
        chk("t1.in_valid_r", bus.proj_in_valid, 1);
        wait_hd(n);
        chk("t1.lat", n, 5);
        chk_beat("t1.b0", 0, 0, 1'b0);
        chk("t1.in_valid_d", bus.proj_in_valid, 0);
        chk("t1.tok_ready_d", bus.tok_ready, 0);
        tick();
        chk_beat("t1.b1", 1, 0, 1'b1);
        tick();
        chk("t1.tok_ready_end", bus.tok_ready, 1);
        chk("t1.hdv_end", bus.hd_valid, 0);
        chk("t1.err", err, 0);

        // Downstream stall on idx0
        bus.hd_ready = 1'b0;
        set_tok(0);
        bus.tok_valid = 1'b1;
        tick();
        bus.tok_valid = 1'b0;
        tick();
        wait_hd(n);
        chk("t2.lat", n, 5);
        for (int c = 0; c < 4; c++) begin
            chk_beat("t2.hold", 0, 0, 1'b0);
            chk("t2.tok_ready", bus.tok_ready, 0);
            tick();
        end
        chk_beat("t2.hold4", 0, 0, 1'b0);
        bus.hd_ready = 1'b1;
        tick();
        chk_beat("t2.b1", 1, 0, 1'b1);
        chk("t2.tok_ready_b1", bus.tok_ready, 0);
        tick();
        chk("t2.tok_ready_end", bus.tok_ready, 1);

        // Timeout: responder silent
        resp_en = 1'b0;
        set_tok(0);
        bus.tok_valid = 1'b1;
        tick();
        bus.tok_valid = 1'b0;
        tick();
        seen_hd = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.hd_valid) seen_hd = 1'b1;
        end
        chk("t3.err_pre", err, 0);
        chk("t3.busy_pre", busy, 1);
        tick();
        chk("t3.err", err, 2'b01);
        chk("t3.idle", bus.tok_ready, 1);
        chk("t3.busy", busy, 0);
        chk("t3.no_hd", seen_hd | bus.hd_valid, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3.err_clr", err, 0);
        resp_en = 1'b1;
        full_token("t3.next", 0);

        // Spurious result pulse in IDLE
        man_pov = 1'b1;
        tick();
        man_pov = 1'b0;
        chk("t4.err", err, 2'b10);
        chk("t4.hdv", bus.hd_valid, 0);
        chk("t4.idle", bus.tok_ready, 1);
        tick();
        chk("t4.hdv2", bus.hd_valid, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4.err_clr", err, 0);

        // Reset in DRAIN after idx0 has transferred
        set_tok(0);
        bus.tok_valid = 1'b1;
        tick();
        bus.tok_valid = 1'b0;
        tick();
        wait_hd(n);
        chk("t5.lat", n, 5);
        tick();
        chk("t5.idx1", bus.hd_idx, 1);
        rst = 1'b1;
        #1;
        chk("t5.hdv", bus.hd_valid, 0);
        chk("t5.idx", bus.hd_idx, 0);
        chk("t5.hd_q", bus.hd_q, 0);
        chk("t5.tok_ready", bus.tok_ready, 1);
        chk("t5.busy", busy, 0);
        chk("t5.in_vec1", bus.proj_in_vec[1], 0);
        chk("t5.in_valid", bus.proj_in_valid, 0);
        tick();
        rst = 1'b0;
        full_token("t5.next", 0);

        // Back-to-back tokens with tok_valid held high
        set_tok(1);
        bus.tok_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk("t6.rdy", bus.tok_ready, 1);
            tick();
            chk("t6.start", bus.proj_start, 1);
            chk("t6.vec_s", bus.proj_in_vec[0], i);
            bus.tok_vec[0] = DW'(i + 1);
            tick();
            chk("t6.no_acc", bus.tok_ready, 0);
            wait_hd(n);
            chk("t6.lat", n, 5);
            chk_beat("t6.b0", 0, i, 1'b0);
            chk("t6.vec_d", bus.proj_in_vec[0], i);
            tick();
            chk_beat("t6.b1", 1, i, 1'b1);
            tick();
        end
        bus.tok_valid = 1'b0;
        tick();
        chk("t6.idle", busy, 0);
        chk("t6.err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
